imem_loader: RTL

Parametrised instruction memory for the mini-MIPS fetch stage with a built-in byte-stream program loader. After reset it zeroes its array with a clear sweep. It then serves single-cycle-latency fetches through a request/valid handshake with stall and fault reporting. Software images are written word-by-word from an 8-bit stream, replacing the file-based preload used in simulation.

---
 rtl/imem_loader_if.sv | 38 +++
 rtl/imem_loader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Fetch and loader signal bundle for imem_loader.
// The slave modport is used by the memory, and the master modport by the fetch stage or loader.
interface imem_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4096
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_stall;
    logic              fetch_ready;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_fault;
    logic              load_start;
    logic [CW-1:0]     load_count;
    logic [7:0]        load_data;
    logic              load_valid;
    logic              load_ready;
    logic              load_busy;
    logic              load_done;

    modport slave (
        input  fetch_req, fetch_pc, fetch_stall,
        input  load_start, load_count, load_data, load_valid,
        output fetch_ready, instr, instr_valid, instr_fault,
        output load_ready, load_busy, load_done
    );

    modport master (
        output fetch_req, fetch_pc, fetch_stall,
        output load_start, load_count, load_data, load_valid,
        input  fetch_ready, instr, instr_valid, instr_fault,
        input  load_ready, load_busy, load_done
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory with clear sweep, registered fetch port and a byte-stream loader.
// Words from the loader are assembled big-endian.
module imem_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4096
) (
    input  logic clk,
    input  logic rst,
    imem_loader_if.slave bus
);
    localparam int BPW = DATA_W / 8;
    localparam int LSB = $clog2(BPW);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;

    state_t            state, state_n;
    logic [AW-1:0]     clr_addr, wr_addr, mem_addr, fetch_idx;
    logic [LSB-1:0]    byte_cnt;
    logic [CW-1:0]     remaining;
    logic [DATA_W-9:0] asm_q;
    logic [DATA_W-1:0] word, mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              take, last_byte, mem_we, done_n;
    logic              fetch_acc, fetch_bad;

    assign take      = (state == LOAD) && bus.load_valid;
    assign last_byte = byte_cnt == LSB'(BPW - 1);
    assign word      = {asm_q, bus.load_data};
    assign fetch_idx = bus.fetch_pc[LSB +: AW];
    assign fetch_bad = (|bus.fetch_pc[LSB-1:0])
                     | (|bus.fetch_pc[ADDR_W-1:LSB+AW]);
    assign fetch_acc = (state == IDLE) && bus.fetch_req
                     && !bus.fetch_stall;

    assign bus.fetch_ready = state == IDLE;
    assign bus.load_ready  = state == LOAD;
    assign bus.load_busy   = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CLEAR;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        mem_we    = 1'b0;
        mem_addr  = clr_addr;
        mem_wdata = '0;
        done_n    = 1'b0;
        unique case (state)
            CLEAR: begin
                mem_we = 1'b1;
                if (clr_addr == AW'(DEPTH - 1)) state_n = IDLE;
            end
            IDLE: begin
                if (bus.load_start) begin
                    if (bus.load_count != '0) state_n = LOAD;
                    else                      done_n  = 1'b1;
                end
            end
            LOAD: begin
                if (take && last_byte) begin
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = word;
                    if (remaining == CW'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr      <= '0;
            wr_addr       <= '0;
            byte_cnt      <= '0;
            remaining     <= '0;
            asm_q         <= '0;
            bus.load_done <= 1'b0;
        end else begin
            bus.load_done <= done_n;
            if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
            if (state == IDLE && bus.load_start) begin
                wr_addr   <= '0;
                byte_cnt  <= '0;
                // Requests beyond the array are truncated to DEPTH words
                remaining <= bus.load_count[AW] ? CW'(DEPTH)
                                                : bus.load_count;
            end
            if (take) begin
                asm_q <= word[DATA_W-9:0];
                if (last_byte) begin
                    byte_cnt  <= '0;
                    wr_addr   <= wr_addr + 1'b1;
                    remaining <= remaining - 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.instr       <= '0;
            bus.instr_valid <= 1'b0;
            bus.instr_fault <= 1'b0;
        end else if (!bus.fetch_stall) begin
            bus.instr_valid <= fetch_acc;
            if (fetch_acc) begin
                bus.instr_fault <= fetch_bad;
                bus.instr       <= fetch_bad ? '0 : mem[fetch_idx];
            end
        end
    end
endmodule
